car_ram_wr_arbiter: RTL and testbench

Write-side controller for the 2-bit car sprite RAM (32x32 entries, 10-bit address). Shares the single RAM write port between two requesters: a CPU bus write channel (req/ack) and an internal fill engine that paints a contiguous address range with one colour (sprite clear/recolour). Sits between the MMIO sprite core registers and the RAM write port. The video read port is untouched.

---
 rtl/car_ram_wr_arbiter.sv | 132 +++++++++++++
 tb/tb_car_ram_wr_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/car_ram_wr_arbiter.sv
// Write-port arbiter for the car sprite RAM: CPU write channel plus a range-fill engine.
// Define CAR_ARB_RR_EN for round-robin arbitration; the default build gives the CPU fixed priority.
module car_ram_wr_arbiter #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_wr_req,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_din,
   output logic                  cpu_ack,
   input  logic                  fill_start,
   input  logic [ADDR_WIDTH-1:0] fill_base,
   input  logic [ADDR_WIDTH:0]   fill_len,
   input  logic [DATA_WIDTH-1:0] fill_color,
   output logic                  fill_busy,
   output logic                  fill_done,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr_w,
   output logic [DATA_WIDTH-1:0] ram_din
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   LEN_ZERO = {(ADDR_WIDTH+1){1'b0}};

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_cur_addr;
   logic [ADDR_WIDTH:0]   r_remaining;
   logic [DATA_WIDTH-1:0] r_color;

   logic w_cpu_req;
   logic w_fill_req;
   logic w_cpu_gnt;
   logic w_fill_gnt;

   // A request is masked while its ack is up so a held req cannot write twice.
   assign w_cpu_req  = cpu_wr_req & ~cpu_ack;
   assign w_fill_req = (r_state == S_FILL);

`ifdef CAR_ARB_RR_EN
   logic r_cpu_won_last;

   assign w_cpu_gnt = w_cpu_req & (~w_fill_req | ~r_cpu_won_last);

   // Remember the winner of the last contended cycle so the other side goes next.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cpu_won_last <= 1'b0;
      end else if (w_cpu_req && w_fill_req) begin
         r_cpu_won_last <= w_cpu_gnt;
      end else begin
         r_cpu_won_last <= r_cpu_won_last;
      end
   end
`else
   assign w_cpu_gnt = w_cpu_req;
`endif

   assign w_fill_gnt = w_fill_req & ~w_cpu_gnt;

   // Fill FSM, grant execution and all registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cur_addr  <= '0;
         r_remaining <= '0;
         r_color     <= '0;
         cpu_ack     <= 1'b0;
         fill_busy   <= 1'b0;
         fill_done   <= 1'b0;
         ram_we      <= 1'b0;
         ram_addr_w  <= '0;
         ram_din     <= '0;
      end else begin
         cpu_ack   <= w_cpu_gnt;
         fill_done <= 1'b0;
         ram_we    <= w_cpu_gnt | w_fill_gnt;
         if (w_cpu_gnt) begin
            ram_addr_w <= cpu_addr;
            ram_din    <= cpu_din;
         end else if (w_fill_gnt) begin
            ram_addr_w <= r_cur_addr;
            ram_din    <= r_color;
         end else begin
            ram_addr_w <= ram_addr_w;
            ram_din    <= ram_din;
         end

         case (r_state)
            S_IDLE: begin
               if (fill_start) begin
                  r_cur_addr  <= fill_base;
                  r_remaining <= fill_len;
                  r_color     <= fill_color;
                  fill_busy   <= 1'b1;
                  r_state     <= (fill_len == LEN_ZERO) ? S_DONE : S_FILL;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_FILL: begin
               // A stalled cycle (CPU granted) neither advances nor counts.
               if (w_fill_gnt) begin
                  r_cur_addr  <= r_cur_addr + ADDR_ONE;
                  r_remaining <= r_remaining - LEN_ONE;
                  r_state     <= (r_remaining == LEN_ONE) ? S_DONE : S_FILL;
               end else begin
                  r_state <= S_FILL;
               end
            end
            S_DONE: begin
               fill_done <= 1'b1;
               fill_busy <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: begin
               fill_busy <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_car_ram_wr_arbiter.sv
// Scoreboard bench for car_ram_wr_arbiter: drivers queue expected RAM writes, a monitor checks them.
module tb_car_ram_wr_arbiter;

   typedef struct {
      logic [9:0] a;
      logic [1:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_wr_req = 1'b0;
   logic [9:0]  cpu_addr = 10'd0;
   logic [1:0]  cpu_din = 2'd0;
   logic        cpu_ack;
   logic        fill_start = 1'b0;
   logic [9:0]  fill_base = 10'd0;
   logic [10:0] fill_len = 11'd0;
   logic [1:0]  fill_color = 2'd0;
   logic        fill_busy;
   logic        fill_done;
   logic        ram_we;
   logic [9:0]  ram_addr_w;
   logic [1:0]  ram_din;

   car_ram_wr_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(2)) dut (
      .clk(clk), .reset(reset),
      .cpu_wr_req(cpu_wr_req), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_ack(cpu_ack),
      .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len), .fill_color(fill_color),
      .fill_busy(fill_busy), .fill_done(fill_done),
      .ram_we(ram_we), .ram_addr_w(ram_addr_w), .ram_din(ram_din)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   wr_t  cpu_q[$];
   wr_t  fill_q[$];
   bit   m_active = 1'b0;
   int   m_start_cyc = 0;
   int   m_done_cyc = -1;
   int   n_fill_wr = 0;
   logic [9:0] last_addr = 10'd0;
   logic [1:0] last_din = 2'd0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: reference model of the fill range plus write/handshake scoreboard.
   initial begin
      wr_t e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (!reset) begin
            if (fill_start && !m_active) begin
               m_active = 1'b1;
               m_start_cyc = cyc;
               for (int i = 0; i < int'(fill_len); i++) begin
                  e.a = fill_base + 10'(i);
                  e.d = fill_color;
                  fill_q.push_back(e);
               end
               if (fill_len == 11'd0) m_done_cyc = cyc + 1;
            end
            if (cyc == m_done_cyc) begin
               chk("fill_done_pulse", int'(fill_done), 1);
               m_active = 1'b0;
               m_done_cyc = -1;
            end else begin
               chk("fill_done_spurious", int'(fill_done), 0);
            end
            chk("fill_busy", int'(fill_busy), int'(m_active));
            if (ram_we) begin
               if (cpu_ack) begin
                  if (cpu_q.size() == 0) begin
                     chk("cpu_unexpected_write", int'(ram_we), 0);
                     last_addr = ram_addr_w;
                     last_din = ram_din;
                  end else begin
                     e = cpu_q.pop_front();
                     chk("cpu_addr", int'(ram_addr_w), int'(e.a));
                     chk("cpu_din", int'(ram_din), int'(e.d));
                     last_addr = e.a;
                     last_din = e.d;
                  end
               end else begin
                  if (fill_q.size() == 0) begin
                     chk("fill_unexpected_write", int'(ram_we), 0);
                     last_addr = ram_addr_w;
                     last_din = ram_din;
                  end else begin
                     e = fill_q.pop_front();
                     chk("fill_addr", int'(ram_addr_w), int'(e.a));
                     chk("fill_din", int'(ram_din), int'(e.d));
                     last_addr = e.a;
                     last_din = e.d;
                     n_fill_wr++;
                     if (fill_q.size() == 0) m_done_cyc = cyc + 1;
                  end
               end
            end else begin
               chk("ack_without_we", int'(cpu_ack), 0);
               chk("addr_hold", int'(ram_addr_w), int'(last_addr));
               chk("din_hold", int'(ram_din), int'(last_din));
               if (m_active && fill_q.size() > 0 && cyc > m_start_cyc)
                  chk("fill_stall", int'(ram_we), 1);
            end
         end
      end
   end

   task automatic cpu_write(input logic [9:0] a, input logic [1:0] d, input bit hold, input int exp_lat);
      wr_t e;
      int  lat;
      bit  got;
      @(negedge clk);
      cpu_wr_req = 1'b1;
      cpu_addr = a;
      cpu_din = d;
      e.a = a;
      e.d = d;
      cpu_q.push_back(e);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 8) begin
         @(posedge clk);
         #1;
         lat++;
         if (cpu_ack) got = 1'b1;
      end
      chk("cpu_ack_timeout", int'(got), 1);
      if (exp_lat > 0) chk("cpu_ack_latency", lat, exp_lat);
      if (hold) begin
         @(posedge clk);
         #1;
         chk("cpu_ack_one_cycle", int'(cpu_ack), 0);
      end
      cpu_wr_req = 1'b0;
   endtask

   task automatic fill_go(input logic [9:0] b, input logic [10:0] l, input logic [1:0] c);
      @(negedge clk);
      fill_start = 1'b1;
      fill_base = b;
      fill_len = l;
      fill_color = c;
      @(negedge clk);
      fill_start = 1'b0;
   endtask

   task automatic wait_fill(input int budget);
      int n = 0;
      while (m_active && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("fill_timeout", int'(m_active), 0);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_cpu_ack"}, int'(cpu_ack), 0);
      chk({tag, "_fill_busy"}, int'(fill_busy), 0);
      chk({tag, "_fill_done"}, int'(fill_done), 0);
      chk({tag, "_ram_we"}, int'(ram_we), 0);
      chk({tag, "_ram_addr_w"}, int'(ram_addr_w), 0);
      chk({tag, "_ram_din"}, int'(ram_din), 0);
   endtask

   initial begin
      int target;
      int n;
      repeat (3) @(negedge clk);
      chk_outputs_zero("reset");
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // CPU single write with req held through the ack cycle.
      cpu_write(10'h155, 2'b10, 1'b1, 1);
      repeat (3) @(negedge clk);

      fill_go(10'h010, 11'd4, 2'd3);
      wait_fill(50);
      fill_go(10'h3FE, 11'd4, 2'd1);
      wait_fill(50);
      fill_go(10'h123, 11'd0, 2'd2);
      wait_fill(50);
      fill_go(10'(($urandom_range(0, 1023))), 11'd1024, 2'd2);
      wait_fill(1100);
      chk("full_fill_count", n_fill_wr, 4 + 4 + 1024);

      // CPU write colliding with the first fill write.
      fork
         fill_go(10'h020, 11'd8, 2'd2);
         begin
            @(negedge clk);
            cpu_write(10'h200, 2'd1, 1'b0, 0);
         end
      join
      wait_fill(50);

      // Back-to-back CPU traffic during a fill.
      fork
         fill_go(10'h040, 11'd10, 2'd1);
         for (int k = 0; k < 6; k++) cpu_write(10'(10'h280 + 10'(k)), 2'(k), 1'b0, 0);
      join
      wait_fill(100);

      // Second start while busy must be ignored.
      fill_go(10'h100, 11'd16, 2'd1);
      repeat (3) @(negedge clk);
      fill_go(10'h300, 11'd5, 2'd2);
      wait_fill(100);

      // Asynchronous reset during the third fill write.
      fill_go(10'h050, 11'd8, 2'd1);
      target = n_fill_wr + 3;
      n = 0;
      while (n_fill_wr < target && n < 50) begin
         @(posedge clk);
         #2;
         n++;
      end
      chk("third_write_reached", int'(n_fill_wr >= target), 1);
      reset = 1'b1;
      #1;
      chk_outputs_zero("async_reset");
      fill_q.delete();
      cpu_q.delete();
      m_active = 1'b0;
      m_done_cyc = -1;
      last_addr = 10'd0;
      last_din = 2'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      fill_go(10'h0A0, 11'd5, 2'd2);
      wait_fill(50);

      // Randomized fills mixed with CPU writes.
      for (int r = 0; r < 8; r++) begin
         fork
            fill_go(10'($urandom_range(0, 1023)), 11'($urandom_range(0, 40)), 2'($urandom_range(0, 3)));
            begin
               repeat ($urandom_range(0, 5)) @(negedge clk);
               for (int k = 0; k < int'($urandom_range(1, 6)); k++)
                  cpu_write(10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3)), 1'b0, 0);
            end
         join
         wait_fill(300);
         repeat (2) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      chk("cpu_q_empty", cpu_q.size(), 0);
      chk("fill_q_empty", fill_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
